// File: rtl/chiplet_types_pkg.sv
// ============================================================================
// chiplet_types_pkg : shared flit and header types for the chiplet link
// Rev 1.0
// ============================================================================
`default_nettype none

package chiplet_types_pkg;

    typedef enum logic [3:0] {
        KOMMA_PACKET = 4'd0,
        LONG_WRITE   = 4'd1,
        LONG_READ    = 4'd2,
        MEM_RESP     = 4'd3,
        MSG          = 4'd4,
        SHORT_WRITE  = 4'd5,
        SHORT_READ   = 4'd6,
        SWITCH_CFG   = 4'd7
    } format_e;

    typedef struct packed {
        logic [7:0]  meta;
        logic [31:0] payload;
    } flit_t;

    // Header view of a flit payload: format in the top nibble, length in the low byte.
    typedef struct packed {
        format_e     fmt;
        logic [3:0]  dest;
        logic [15:0] tag;
        logic [7:0]  len;
    } hdr_t;

endpackage

`default_nettype wire

// File: rtl/endnode_rx_deframer_pkg.sv
// ============================================================================
// endnode_rx_deframer_pkg : deframer states, constants and header length decode
// Rev 1.0
// ============================================================================
`default_nettype none

package endnode_rx_deframer_pkg;
    import chiplet_types_pkg::*;

    localparam int MAX_PKT_FLITS = 129;
    // Body counter must hold 1+L for an 8-bit L (up to 256).
    localparam int CNT_W = $clog2(MAX_PKT_FLITS) + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR      = 3'd1,
        BODY     = 3'd2,
        WAIT_END = 3'd3,
        DROP     = 3'd4
    } state_e;

    typedef struct packed {
        logic             ok;
        logic [CNT_W-1:0] n;
    } body_len_t;

    function automatic body_len_t body_len(input logic [31:0] payload);
        hdr_t      h;
        body_len_t r;
        h    = hdr_t'(payload);
        r.ok = 1'b1;
        r.n  = '0;
        case (h.fmt)
            LONG_WRITE:             r.n = CNT_W'(h.len) + CNT_W'(1);
            LONG_READ:              r.n = CNT_W'(1);
            MEM_RESP, MSG:          r.n = CNT_W'(h.len);
            SHORT_WRITE:            r.n = CNT_W'(h.len[3:0]);
            SHORT_READ, SWITCH_CFG: r.n = '0;
            default:                r.ok = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/endnode_rx_deframer_if.sv
// ============================================================================
// endnode_rx_deframer_if : flit input stream and committed-packet read port
// Rev 1.0
// ============================================================================
`default_nettype none

interface endnode_rx_deframer_if #(
    parameter int DEPTH  = 256,
    parameter int DROP_W = 8
);
    import chiplet_types_pkg::*;

    flit_t                 flit_in;
    logic                  flit_valid_in;
    logic                  start_in;
    logic                  end_in;
    logic                  err_in;
    logic                  rd_en;
    flit_t                 rd_flit;
    logic                  rd_empty;
    logic [$clog2(DEPTH):0] free_slots;
    logic                  send_ack;
    logic                  send_nack;
    logic                  busy;
    logic [DROP_W-1:0]     drop_cnt;

    modport master (
        output flit_in, flit_valid_in, start_in, end_in, err_in, rd_en,
        input  rd_flit, rd_empty, free_slots, send_ack, send_nack, busy, drop_cnt
    );

    modport slave (
        input  flit_in, flit_valid_in, start_in, end_in, err_in, rd_en,
        output rd_flit, rd_empty, free_slots, send_ack, send_nack, busy, drop_cnt
    );

endinterface

`default_nettype wire

// File: rtl/endnode_rx_pkt_fifo.sv
// ============================================================================
// endnode_rx_pkt_fifo : flit FIFO with a speculative write pointer that is
//                       either committed or rolled back per packet
// Rev 1.0
// ============================================================================
`default_nettype none

module endnode_rx_pkt_fifo
    import chiplet_types_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   wr_en_i,
    input  wire flit_t                  wr_data_i,
    input  wire logic                   commit_i,
    input  wire logic                   rollback_i,
    input  wire logic                   rd_en_i,
    output flit_t                       rd_data_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic [$clog2(DEPTH):0]      free_slots_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    flit_t            mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_spec_q;
    logic [PW-1:0]    occupancy;
    logic             do_wr;
    logic             do_rd;

    // Occupancy counts speculative flits so an open packet cannot overrun the reader.
    assign occupancy    = wr_spec_q - rd_ptr_q;
    assign full_o       = (occupancy == PW'(DEPTH));
    assign empty_o      = (rd_ptr_q == wr_ptr_q);
    assign free_slots_o = PW'(DEPTH) - occupancy;
    assign do_wr        = wr_en_i && !rollback_i && !full_o;
    assign do_rd        = rd_en_i && !empty_o;
    assign rd_data_o    = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_spec_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            wr_spec_q <= '0;
        end else begin
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (rollback_i) begin
                wr_spec_q <= wr_ptr_q;
            end else if (do_wr) begin
                wr_spec_q <= wr_spec_q + PW'(1);
            end
            if (commit_i) begin
                wr_ptr_q <= wr_spec_q;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/endnode_rx_deframer.sv
// ============================================================================
// endnode_rx_deframer : parses received packets, stages them speculatively and
//                       releases only complete, length-checked packets
// Rev 1.0
// ============================================================================
`default_nettype none

module endnode_rx_deframer
    import chiplet_types_pkg::*;
    import endnode_rx_deframer_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int DROP_W = 8
) (
    input  wire logic            CLK,
    input  wire logic            RST,
    endnode_rx_deframer_if.slave bus
);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    send_ack_q, send_ack_d;
    logic                    send_nack_q, send_nack_d;
    logic [DROP_W-1:0]       drop_cnt_q;
    logic                    fail;
    logic                    wr_en;
    logic                    commit;
    logic                    fifo_full;
    body_len_t               hdr_len;
    flit_t                   fifo_rd_flit;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_free;

    assign hdr_len = body_len(bus.flit_in.payload);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fail        = 1'b0;
        wr_en       = 1'b0;
        commit      = 1'b0;
        send_ack_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    state_d = HDR;
                end
            end
            DROP: begin
                if (!bus.err_in) begin
                    if (bus.start_in) begin
                        state_d = HDR;
                    end else if (bus.end_in) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                // Inside a packet: err > start > end > flit.
                if (bus.err_in) begin
                    fail    = 1'b1;
                    state_d = DROP;
                end else if (bus.start_in) begin
                    fail    = 1'b1;
                    state_d = HDR;
                end else if (bus.end_in) begin
                    if (state_q == WAIT_END) begin
                        commit     = 1'b1;
                        send_ack_d = 1'b1;
                    end else begin
                        fail = 1'b1;
                    end
                    state_d = IDLE;
                end else if (bus.flit_valid_in) begin
                    if (state_q == WAIT_END || fifo_full || (state_q == HDR && !hdr_len.ok)) begin
                        fail    = 1'b1;
                        state_d = DROP;
                    end else begin
                        wr_en = 1'b1;
                        if (state_q == HDR) begin
                            cnt_d   = hdr_len.n;
                            state_d = (hdr_len.n == '0) ? WAIT_END : BODY;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                            if (cnt_q == CNT_W'(1)) begin
                                state_d = WAIT_END;
                            end
                        end
                    end
                end
            end
        endcase
        send_nack_d = fail;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            send_ack_q  <= 1'b0;
            send_nack_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            send_ack_q  <= send_ack_d;
            send_nack_q <= send_nack_d;
            if (fail && drop_cnt_q != '1) begin
                drop_cnt_q <= drop_cnt_q + DROP_W'(1);
            end
        end
    end

    endnode_rx_pkt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (CLK),
        .rst          (RST),
        .wr_en_i      (wr_en),
        .wr_data_i    (bus.flit_in),
        .commit_i     (commit),
        .rollback_i   (fail),
        .rd_en_i      (bus.rd_en),
        .rd_data_o    (fifo_rd_flit),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full),
        .free_slots_o (fifo_free)
    );

    assign bus.rd_flit    = fifo_rd_flit;
    assign bus.rd_empty   = fifo_empty;
    assign bus.free_slots = fifo_free;
    assign bus.send_ack   = send_ack_q;
    assign bus.send_nack  = send_nack_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.drop_cnt   = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_endnode_rx_deframer.sv
// ============================================================================
// tb_endnode_rx_deframer : directed and randomized packets against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_endnode_rx_deframer;
    import chiplet_types_pkg::*;

    localparam int DEPTH  = 256;
    localparam int DROP_W = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    endnode_rx_deframer_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

    endnode_rx_deframer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int    n_cmp     = 0;
    int    n_fail    = 0;
    int    ack_seen  = 0;
    int    nack_seen = 0;
    int    both_seen = 0;
    flit_t model_q[$];
    int    exp_drop  = 0;

    always @(posedge CLK) begin
        if (bus.send_ack)                  ack_seen  <= ack_seen + 1;
        if (bus.send_nack)                 nack_seen <= nack_seen + 1;
        if (bus.send_ack && bus.send_nack) both_seen <= both_seen + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Body flits after the header from the format/length table; -1 marks a bad format.
    function automatic int spec_body(input logic [31:0] p);
        int l;
        l = int'(p[7:0]);
        case (p[31:28])
            4'd1:       return 1 + l;
            4'd2:       return 1;
            4'd3, 4'd4: return l;
            4'd5:       return l % 16;
            4'd6, 4'd7: return 0;
            default:    return -1;
        endcase
    endfunction

    task automatic run_pkt(input string tag, input logic [3:0] fmt, input logic [7:0] len,
                           input int nbody, input int err_at, input bit fixed);
        flit_t f;
        flit_t pkt[$];
        int    n_exp, cap, a0, n0;
        bit    ok;
        f.meta    = 8'($urandom);
        f.payload = {fmt, 20'($urandom), len};
        pkt.push_back(f);
        for (int i = 0; i < nbody; i++) begin
            if (fixed && i > 0) begin
                f = {8'hA5, 32'h08675309};
            end else begin
                f.meta    = 8'($urandom);
                f.payload = $urandom;
            end
            pkt.push_back(f);
        end
        n_exp = spec_body(pkt[0].payload);
        cap   = DEPTH - model_q.size();
        ok    = 1'b1;
        for (int k = 0; k < pkt.size(); k++) begin
            if (k == err_at || n_exp < 0 || k > n_exp || k >= cap) begin
                ok = 1'b0;
                break;
            end
        end
        if (ok && nbody < n_exp) ok = 1'b0;

        a0 = ack_seen;
        n0 = nack_seen;
        bus.start_in = 1'b1;
        step();
        bus.start_in = 1'b0;
        for (int k = 0; k < pkt.size(); k++) begin
            bus.flit_in       = pkt[k];
            bus.flit_valid_in = 1'b1;
            bus.err_in        = (k == err_at);
            step();
        end
        bus.flit_valid_in = 1'b0;
        bus.err_in        = 1'b0;
        bus.end_in        = 1'b1;
        step();
        bus.end_in = 1'b0;
        check({tag, " ack_after_end"}, bus.send_ack, ok);
        step();
        check({tag, " ack_width"}, bus.send_ack, 0);

        if (ok) begin
            foreach (pkt[k]) model_q.push_back(pkt[k]);
        end else if (exp_drop < 255) begin
            exp_drop++;
        end
        check({tag, " acks"}, ack_seen - a0, ok ? 1 : 0);
        check({tag, " nacks"}, nack_seen - n0, ok ? 0 : 1);
        check({tag, " drop_cnt"}, bus.drop_cnt, exp_drop);
        check({tag, " busy"}, bus.busy, 0);
        check({tag, " free_slots"}, bus.free_slots, DEPTH - model_q.size());
        check({tag, " rd_empty"}, bus.rd_empty, model_q.size() == 0);
    endtask

    task automatic drain(input string tag, input int n);
        flit_t e;
        for (int i = 0; i < n; i++) begin
            e = model_q.pop_front();
            check({tag, " rd_flit"}, bus.rd_flit, e);
            bus.rd_en = 1'b1;
            step();
            bus.rd_en = 1'b0;
        end
        check({tag, " drained_free"}, bus.free_slots, DEPTH - model_q.size());
        check({tag, " drained_empty"}, bus.rd_empty, model_q.size() == 0);
    endtask

    initial begin
        int    a0, n0, n, nbody, err_at;
        logic [3:0] fmt;
        logic [7:0] len;
        flit_t f;

        bus.flit_in       = '0;
        bus.flit_valid_in = 1'b0;
        bus.start_in      = 1'b0;
        bus.end_in        = 1'b0;
        bus.err_in        = 1'b0;
        bus.rd_en         = 1'b0;
        RST = 1'b1;
        repeat (3) step();
        check("rst rd_empty", bus.rd_empty, 1);
        check("rst free_slots", bus.free_slots, DEPTH);
        check("rst send_ack", bus.send_ack, 0);
        check("rst send_nack", bus.send_nack, 0);
        check("rst busy", bus.busy, 0);
        check("rst drop_cnt", bus.drop_cnt, 0);
        check("rst rd_flit", bus.rd_flit, 0);
        RST = 1'b0;
        step();

        // Long write L=2: header, address, two fixed data words.
        run_pkt("lw2", 4'd1, 8'd2, 3, -1, 1'b1);
        drain("lw2", 4);

        run_pkt("srd", 4'd6, 8'd0, 0, -1, 1'b0);
        run_pkt("msg0", 4'd4, 8'd0, 0, -1, 1'b0);
        drain("srd_msg", 2);

        run_pkt("lw_under", 4'd1, 8'd2, 2, -1, 1'b0);

        run_pkt("mr_err", 4'd3, 8'd9, 9, 2, 1'b0);
        run_pkt("sw_after_err", 4'd5, 8'h13, 3, -1, 1'b0);
        drain("sw", 4);

        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        check("empty_pop free_slots", bus.free_slots, DEPTH);
        check("empty_pop rd_empty", bus.rd_empty, 1);

        // Second maximum long write overflows on its 128th write.
        run_pkt("lw127a", 4'd1, 8'd127, 128, -1, 1'b0);
        run_pkt("lw127b", 4'd1, 8'd127, 128, -1, 1'b0);
        check("overflow free_slots", bus.free_slots, 127);
        drain("lw127a", 129);

        // Restart: a new start komma mid-packet aborts the open packet.
        a0 = ack_seen;
        n0 = nack_seen;
        bus.start_in = 1'b1; step(); bus.start_in = 1'b0;
        f = {8'h11, 4'd2, 20'h0, 8'd0};
        bus.flit_in = f; bus.flit_valid_in = 1'b1; step(); bus.flit_valid_in = 1'b0;
        bus.start_in = 1'b1; step(); bus.start_in = 1'b0;
        check("restart nack", bus.send_nack, 1);
        f = {8'h22, 4'd6, 20'h5, 8'd0};
        bus.flit_in = f; bus.flit_valid_in = 1'b1; step(); bus.flit_valid_in = 1'b0;
        bus.end_in = 1'b1; step(); bus.end_in = 1'b0;
        check("restart ack", bus.send_ack, 1);
        step();
        exp_drop++;
        model_q.push_back(f);
        check("restart acks", ack_seen - a0, 1);
        check("restart nacks", nack_seen - n0, 1);
        check("restart drop_cnt", bus.drop_cnt, exp_drop);
        drain("restart", 1);

        // Reset in the middle of a body.
        n0 = nack_seen;
        a0 = ack_seen;
        bus.start_in = 1'b1; step(); bus.start_in = 1'b0;
        bus.flit_in = {8'h33, 4'd1, 20'h0, 8'd5}; bus.flit_valid_in = 1'b1; step();
        bus.flit_in = {8'h44, 32'hDEADBEEF}; step(); bus.flit_valid_in = 1'b0;
        RST = 1'b1; step(); RST = 1'b0;
        model_q.delete();
        exp_drop = 0;
        check("midrst busy", bus.busy, 0);
        check("midrst rd_empty", bus.rd_empty, 1);
        check("midrst free_slots", bus.free_slots, DEPTH);
        step();
        check("midrst nacks", nack_seen - n0, 0);
        check("midrst acks", ack_seen - a0, 0);
        check("midrst drop_cnt", bus.drop_cnt, 0);
        run_pkt("after_rst", 4'd4, 8'd3, 3, -1, 1'b0);
        drain("after_rst", 4);

        for (int it = 0; it < 30; it++) begin
            fmt = 4'($urandom_range(0, 9));
            len = 8'($urandom_range(0, 10));
            n   = spec_body({fmt, 20'h0, len});
            if (n < 0) begin
                nbody = $urandom_range(0, 2);
            end else begin
                case ($urandom_range(0, 5))
                    0:       nbody = (n > 0) ? n - 1 : n;
                    1:       nbody = n + 1;
                    default: nbody = n;
                endcase
            end
            err_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nbody)) : -1;
            run_pkt("rand", fmt, len, nbody, err_at, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                drain("rand", $urandom_range(0, model_q.size()));
            end
        end
        drain("final", model_q.size());
        check("ack_nack_overlap", both_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
